// File: rtl/pipeline_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer: state encodings,
// register constants and the bundle of interstage control outputs.
package pipeline_pkg;

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_MEM_WAIT = 2'd1;
  localparam logic [1:0] ST_ERROR    = 2'd2;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // Width of the WB control field carried by the MEM/WB register.
  localparam int WB_W = 2;

  typedef enum logic [1:0] {
    S_RUN      = ST_RUN,
    S_MEM_WAIT = ST_MEM_WAIT,
    S_ERROR    = ST_ERROR
  } state_e;

  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic ifid_flush;
    logic idex_en;
    logic idex_flush;
    logic exmem_en;
    logic memwb_en;
    logic memwb_bubble;
  } ctrl_t;

  localparam ctrl_t CTRL_NORMAL   = ctrl_t'(8'b1101_0110);
  localparam ctrl_t CTRL_FREEZE   = ctrl_t'(8'b0000_0011);
  localparam ctrl_t CTRL_BRANCH   = ctrl_t'(8'b1111_1110);
  // Load-use: hold PC and IF/ID, inject a bubble into ID/EX, let older work drain.
  localparam ctrl_t CTRL_LOAD_USE = ctrl_t'(8'b0001_1110);
  localparam ctrl_t CTRL_HALT     = ctrl_t'(8'b0000_0000);

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Combinational load-use detector: the load in EX writes a register that the
// instruction in ID reads.
module hazard_detect
  import pipeline_pkg::*;
(
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       ex_memRead,
  input  logic [4:0] ex_rd,
  output logic       load_use
);

  assign load_use = ex_memRead && (ex_rd != REG_ZERO) &&
                    ((ex_rd == id_rs) || (ex_rd == id_rt));

endmodule

// File: rtl/pipeline_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline: resolves memory waits,
// taken branches and load-use hazards; tracks stall cycles and memory timeouts.
module pipeline_ctrl
  import pipeline_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             ex_memRead,
  input  logic [4:0]       ex_rd,
  input  logic             ex_branchTaken,
  input  logic             mem_req,
  input  logic             mem_ack,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_en,
  output logic             idex_flush,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             memwb_bubble,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_count
);

  localparam int TMR_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(MEM_TIMEOUT - 1);

  state_e             state_q, state_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [CNT_W-1:0]   stall_count_q, stall_count_d;
  logic               mem_timeout_q, mem_timeout_d;
  logic               load_use;
  ctrl_t              hazard_ctrl;
  ctrl_t              ctrl;

  hazard_detect u_hazard_detect (
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .ex_memRead (ex_memRead),
    .ex_rd      (ex_rd),
    .load_use   (load_use)
  );

  // Branch outranks load-use: the dependent ID instruction is flushed anyway.
  always_comb begin
    hazard_ctrl = CTRL_NORMAL;
    if (ex_branchTaken) begin
      hazard_ctrl = CTRL_BRANCH;
    end else if (load_use) begin
      hazard_ctrl = CTRL_LOAD_USE;
    end
  end

  always_comb begin
    state_d       = state_q;
    timer_d       = timer_q;
    mem_timeout_d = mem_timeout_q;
    ctrl          = CTRL_NORMAL;
    case (state_q)
      S_RUN: begin
        if (mem_req && !mem_ack) begin
          ctrl    = CTRL_FREEZE;
          state_d = S_MEM_WAIT;
          timer_d = '0;
        end else begin
          ctrl = hazard_ctrl;
        end
      end
      S_MEM_WAIT: begin
        if (!mem_ack) begin
          ctrl = CTRL_FREEZE;
          if (timer_q == TMR_LAST) begin
            state_d       = S_ERROR;
            mem_timeout_d = 1'b1;
          end else begin
            timer_d = timer_q + TMR_W'(1);
          end
        end else begin
          ctrl    = hazard_ctrl;
          state_d = S_RUN;
        end
      end
      S_ERROR: begin
        ctrl = CTRL_HALT;
      end
      default: begin
        ctrl    = CTRL_HALT;
        state_d = S_RUN;
      end
    endcase
    if (reset) begin
      ctrl = CTRL_HALT;
    end
  end

  always_comb begin
    stall_count_d = stall_count_q;
    if (!ctrl.pc_en && (stall_count_q != {CNT_W{1'b1}})) begin
      stall_count_d = stall_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= S_RUN;
      timer_q       <= '0;
      stall_count_q <= '0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      stall_count_q <= stall_count_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

  assign pc_en        = ctrl.pc_en;
  assign ifid_en      = ctrl.ifid_en;
  assign ifid_flush   = ctrl.ifid_flush;
  assign idex_en      = ctrl.idex_en;
  assign idex_flush   = ctrl.idex_flush;
  assign exmem_en     = ctrl.exmem_en;
  assign memwb_en     = ctrl.memwb_en;
  assign memwb_bubble = ctrl.memwb_bubble;
  assign mem_timeout  = mem_timeout_q;
  assign stall_count  = stall_count_q;

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
Central stall/flush sequencer for the 5-stage pipeline. It drives the enable and flush/bubble controls of the interstage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC. It resolves three hazard classes: multi-cycle data-memory waits, taken branches and load-use hazards. It also keeps a stall performance counter and a sticky memory-timeout flag.

Parameters:
MEM_TIMEOUT, 15, max cycles spent in MEM_WAIT without mem_ack before entering ERROR (legal range >= 1)
CNT_W, 16, width of stall_count

Ports:
clock  in  1  system clock, all state updates on posedge
reset  in  1  asynchronous, active-high; clears all state immediately
id_rs  in  5  rs field of instruction in ID
id_rt  in  5  rt field of instruction in ID
ex_memRead  in  1  instruction in EX is a load
ex_rd  in  5  destination register of instruction in EX
ex_branchTaken  in  1  branch resolved taken in EX this cycle
mem_req  in  1  instruction in MEM accesses data memory
mem_ack  in  1  data memory completes the access this cycle
pc_en  out  1  PC update enable
ifid_en  out  1  IF/ID load enable
ifid_flush  out  1  IF/ID loads a NOP
idex_en  out  1  ID/EX load enable
idex_flush  out  1  ID/EX loads a bubble (control bits 0)
exmem_en  out  1  EX/MEM load enable
memwb_en  out  1  MEM/WB load enable
memwb_bubble  out  1  MEM/WB loads WB=0 (no register write)
mem_timeout  out  1  sticky error flag
stall_count  out  CNT_W  cycles with pc_en=0, saturating

Behaviour:
- State machine: RUN, MEM_WAIT, ERROR. Reset state is RUN. On reset: wait timer=0, stall_count=0, mem_timeout=0.
- While reset is asserted, all enables, flushes and memwb_bubble are 0.
- Control outputs are combinational from the current state and current inputs, so a stall takes effect in the same cycle. mem_timeout and stall_count are registered.
- "Freeze" means pc_en=ifid_en=idex_en=exmem_en=0, memwb_en=1, memwb_bubble=1, all flushes 0. The instruction already in WB is never written twice.
- "Normal" means all enables=1, all flushes=0, memwb_bubble=0.
- load_use = ex_memRead && ex_rd!=0 && (ex_rd==id_rs || ex_rd==id_rt).
- RUN, evaluated in strict priority order:
  1. mem_req && !mem_ack: freeze; next state MEM_WAIT; timer<=0.
  2. ex_branchTaken: normal, plus ifid_flush=1 and idex_flush=1. Branch wins over load_use because the ID instruction is discarded anyway.
  3. load_use: pc_en=0, ifid_en=0, idex_flush=1; exmem_en=memwb_en=1.
  4. Otherwise: normal.
- MEM_WAIT:
  - !mem_ack && timer==MEM_TIMEOUT-1: freeze; next state ERROR; mem_timeout<=1.
  - !mem_ack otherwise: freeze; timer<=timer+1.
  - mem_ack: evaluate rules 2-4 as in RUN (rule 1 treated as satisfied); next state RUN.
- ERROR: all enables 0, all flushes 0, memwb_bubble 0. Only reset exits ERROR; mem_timeout stays 1 until then.
- mem_req && mem_ack in the same RUN cycle is a single-cycle access: no stall.
- stall_count: +1 on every clock where pc_en==0, including ERROR cycles. Holds at 2^CNT_W-1 (no wrap).
- Timer width: $clog2(MEM_TIMEOUT+1). The timer is don't-care outside MEM_WAIT.
- Reset asserted mid-MEM_WAIT or in ERROR: immediate return to RUN with all counters cleared.

Decomposition:
- Shared package pipeline_pkg:
  - state encoding localparams ST_RUN=2'd0, ST_MEM_WAIT=2'd1, ST_ERROR=2'd2
  - REG_ZERO=5'd0
  - WB field width constant (2), shared with the MEM/WB register
- Sub-module hazard_detect: purely combinational load_use comparator. Inputs id_rs, id_rt, ex_memRead, ex_rd; output load_use.
- pipeline_ctrl instantiates hazard_detect and contains the FSM, timer and counter.

Test Plan:
- Load-use: ex_memRead=1, ex_rd=8, id_rs=8, no branch or mem -> pc_en=0, ifid_en=0, idex_flush=1, exmem_en=1, memwb_en=1; stall_count +1. Repeat with ex_rd=0 -> normal, no stall.
- Branch vs load-use: ex_branchTaken=1 and load_use=1 in the same cycle -> pc_en=1, ifid_flush=1, idex_flush=1; stall_count unchanged.
- Memory wait: mem_req=1, mem_ack=0 for 3 cycles, then mem_ack=1 -> freeze with memwb_bubble=1 for 3 cycles, normal in the ack cycle, state back to RUN; stall_count=3.
- Timeout with MEM_TIMEOUT=4: mem_req held, mem_ack=0 -> freeze cycles 0..4, ERROR from cycle 5, mem_timeout=1, all enables 0. Separate run with mem_ack at cycle 4 -> no error.
- Reset mid-wait: assert reset during MEM_WAIT -> state RUN, stall_count=0, mem_timeout=0, all outputs 0 while reset is high, without waiting for a clock edge.
- Saturation with CNT_W=4: hold in ERROR for 20 cycles -> stall_count stops at 15.
